// File: rtl/fixed_point_scanner.sv
// Sweeps every W-bit state through an external next-state stage and streams each
// fixed point (next == current) out over a valid/ready slot, then reports the count.
module fixed_point_scanner #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] net_x,
    input  logic [W-1:0] net_next,
    output logic         fp_valid,
    input  logic         fp_ready,
    output logic [W-1:0] fp_state,
    output logic [W:0]   fp_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [W-1:0] CAND_MAX = '1;
    localparam logic [W-1:0] CAND_ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W:0]   CNT_ONE  = {{W{1'b0}}, 1'b1};

    state_t       state, state_n;
    logic [W-1:0] cand, cand_n;
    logic         fp_valid_n, done_n;
    logic [W-1:0] fp_state_n;
    logic [W:0]   fp_count_n;
    logic         hit, slot_free, accept;

    // net_x is the candidate register itself, so the next-state stage sees no path from start
    assign net_x     = cand;
    assign hit       = (net_next == cand);
    assign slot_free = !fp_valid || fp_ready;
    assign accept    = fp_valid && fp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cand     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fp_valid <= 1'b0;
            fp_state <= '0;
            fp_count <= '0;
        end else begin
            state    <= state_n;
            cand     <= cand_n;
            busy     <= (state_n != IDLE);
            done     <= done_n;
            fp_valid <= fp_valid_n;
            fp_state <= fp_state_n;
            fp_count <= fp_count_n;
        end
    end

    always_comb begin
        state_n    = state;
        cand_n     = cand;
        done_n     = done;
        fp_valid_n = accept ? 1'b0 : fp_valid;
        fp_state_n = fp_state;
        fp_count_n = fp_count;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n    = SCAN;
                    cand_n     = '0;
                    fp_count_n = '0;
                    done_n     = 1'b0;
                end
            end
            SCAN: begin
                // A hit with the slot still occupied stalls the sweep so nothing is dropped
                if (!hit || slot_free) begin
                    if (hit) begin
                        fp_valid_n = 1'b1;
                        fp_state_n = cand;
                        fp_count_n = fp_count + CNT_ONE;
                    end
                    if (cand == CAND_MAX) begin
                        state_n = DRAIN;
                    end else begin
                        cand_n = cand + CAND_ONE;
                    end
                end
            end
            DRAIN: begin
                if (!fp_valid || accept) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fixed_point_scanner.sv
// Scoreboard bench for fixed_point_scanner: expected fixed points are queued at start
// and popped as the slot is accepted, with gene-net and identity next-state stages.
module tb_fixed_point_scanner;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n, start, fp_ready;
    logic         busy, done, fp_valid;
    logic [W-1:0] net_x, net_next, fp_state;
    logic [W:0]   fp_count;

    int           n_vec  = 0;
    int           n_miss = 0;
    logic [W-1:0] exp_q[$];
    logic         ident  = 1'b0;
    int           ready_mode = 0;   // 0: always ready, 1: toggle, 2: low for ready_hold cycles
    int           ready_hold = 0;
    logic         hold_chk = 1'b0;
    logic         have_prev = 1'b0;
    logic [W-1:0] exp_x;

    always #5 clk = ~clk;

    // Gene-network stage: rotate-left then flip gene 0 preserves no state except 0x00 and 0x53
    function automatic logic [W-1:0] gene(input logic [W-1:0] x);
        if (x == 8'h00 || x == 8'h53) return x;
        return {x[W-2:0], x[W-1]} ^ 8'h01;
    endfunction

    assign net_next = ident ? net_x : gene(net_x);

    fixed_point_scanner #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .net_x(net_x), .net_next(net_next), .fp_valid(fp_valid), .fp_ready(fp_ready),
        .fp_state(fp_state), .fp_count(fp_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: fp_ready = 1'b1;
            1: fp_ready = ~fp_ready;
            default: begin
                if (ready_hold > 0) begin
                    fp_ready = 1'b0;
                    ready_hold--;
                end else begin
                    fp_ready = 1'b1;
                end
            end
        endcase
    end

    always @(negedge clk) begin
        if (rst_n && fp_valid && fp_ready) begin
            if (exp_q.size() == 0) chk("fp_unexpected", 32'(fp_state), 32'hDEAD);
            else chk("fp_state", 32'(fp_state), 32'(exp_q.pop_front()));
        end
        if (hold_chk) begin
            if (have_prev) chk("net_x_hold", 32'(net_x), 32'(exp_x));
            exp_x = net_x + ((busy && (!fp_valid || fp_ready) && net_x != 8'hFF) ? 8'd1 : 8'd0);
            have_prev = 1'b1;
        end else begin
            have_prev = 1'b0;
        end
    end

    task automatic push_expected();
        for (int x = 0; x < (1 << W); x++) begin
            logic [W-1:0] xv;
            xv = W'(x);
            if ((ident ? xv : gene(xv)) == xv) exp_q.push_back(xv);
        end
    endtask

    task automatic pulse_start();
        push_expected();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    int cyc;

    initial begin
        rst_n = 1'b0; start = 1'b0; fp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(fp_valid), 0);
        chk("rst_state", 32'(fp_state), 0);
        chk("rst_count", 32'(fp_count), 0);
        chk("rst_net_x", 32'(net_x), 0);
        rst_n = 1'b1;

        // 1: gene net, always ready
        pulse_start();
        chk("t1_busy", 32'(busy), 1);
        wait_done(400, cyc);
        chk("t1_count", 32'(fp_count), 2);
        chk("t1_done", 32'(done), 1);
        chk("t1_busy_low", 32'(busy), 0);
        chk("t1_q_empty", 32'(exp_q.size()), 0);

        // 2: identity net, always ready, latency bound
        ident = 1'b1;
        pulse_start();
        wait_done(400, cyc);
        chk("t2_latency_ok", 32'(cyc + 1 <= (1 << W) + 2), 1);
        chk("t2_count", 32'(fp_count), 32'h100);
        chk("t2_q_empty", 32'(exp_q.size()), 0);

        // 3: identity net, ready toggling; net_x must hold while stalled
        ready_mode = 1;
        pulse_start();
        hold_chk = 1'b1;
        wait_done(1200, cyc);
        hold_chk = 1'b0;
        chk("t3_count", 32'(fp_count), 32'h100);
        chk("t3_q_empty", 32'(exp_q.size()), 0);

        // 4: gene net, consumer stalled for 300 cycles
        ident = 1'b0;
        ready_mode = 2;
        ready_hold = 302;
        pulse_start();
        repeat (150) @(posedge clk);
        #1;
        chk("t4_valid", 32'(fp_valid), 1);
        chk("t4_slot", 32'(fp_state), 32'h00);
        chk("t4_stall_x", 32'(net_x), 32'h53);
        chk("t4_busy", 32'(busy), 1);
        chk("t4_done", 32'(done), 0);
        wait_done(800, cyc);
        chk("t4_count", 32'(fp_count), 2);
        chk("t4_q_empty", 32'(exp_q.size()), 0);

        // 5: reset mid-sweep at cand 0x40, then a clean rescan
        ready_mode = 0;
        pulse_start();
        cyc = 0;
        while (net_x != 8'h40 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t5_reach_40", 32'(net_x), 32'h40);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        chk("t5_valid", 32'(fp_valid), 0);
        chk("t5_state", 32'(fp_state), 0);
        chk("t5_count", 32'(fp_count), 0);
        chk("t5_net_x", 32'(net_x), 0);
        rst_n = 1'b1;
        exp_q.delete();
        pulse_start();
        wait_done(400, cyc);
        chk("t5_recount", 32'(fp_count), 2);
        chk("t5_q_empty", 32'(exp_q.size()), 0);

        // 6: start held high; a second sweep only begins from IDLE
        push_expected();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        wait_done(400, cyc);
        chk("t6_first_count", 32'(fp_count), 2);
        push_expected();
        @(posedge clk); #1;
        chk("t6_done_clr", 32'(done), 0);
        chk("t6_busy", 32'(busy), 1);
        chk("t6_count_clr", 32'(fp_count), 0);
        start = 1'b0;
        wait_done(400, cyc);
        chk("t6_second_count", 32'(fp_count), 2);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_q_empty", 32'(exp_q.size()), 0);
        chk("t6_idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
